// File: rtl/av2_coeff_pkg.sv
// Shared types and constants for the AV2 coefficient unpacker.
package av2_coeff_pkg;

    // Block-level sequencing: EOB symbol, level symbols, zero fill.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EOB   = 2'd1,
        ST_LEVEL = 2'd2,
        ST_ZFILL = 2'd3
    } state_e;

    // Smallest transform side is 4 samples.
    localparam int MIN_TX_LOG2 = 2;

    // Level symbol layout, counted down from the symbol MSB:
    // sign at SYM_W-SYM_SIGN_OFS, magnitude from SYM_W-SYM_MAG_MSB_OFS down to bit 0.
    localparam int SYM_SIGN_OFS    = 1;
    localparam int SYM_MAG_MSB_OFS = 2;

    // Clamp a requested side log2 into the supported range.
    function automatic logic [2:0] clamp_log2(input logic [2:0] v, input logic [2:0] max_log2);
        logic [2:0] r;
        r = v;
        if (v < 3'(MIN_TX_LOG2)) begin
            r = 3'(MIN_TX_LOG2);
        end else if (v > max_log2) begin
            r = max_log2;
        end
        return r;
    endfunction

endpackage

// File: rtl/av2_coeff_unpacker_scan_pos_map.sv
// Scan-order to raster-position mapping for the coefficient unpacker.
// Row scan is the identity; column scan walks down each column first.
module av2_scan_pos_map #(
    parameter int MAX_TX_LOG2 = 6,
    parameter int POS_W       = 2 * MAX_TX_LOG2
) (
    input  logic [POS_W-1:0] k,
    input  logic [2:0]       w_log2,
    input  logic [2:0]       h_log2,
    input  logic             scan_col,
    output logic [POS_W-1:0] pos
);

    logic [POS_W-1:0] row_mask;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;

    // Column scan: low h bits of k pick the row, the rest pick the column.
    always_comb begin
        row_mask = (POS_W'(1) << h_log2) - POS_W'(1);
        row      = k & row_mask;
        col      = k >> h_log2;
        if (scan_col) begin
            pos = (row << w_log2) | col;
        end else begin
            pos = k;
        end
    end

endmodule

// File: rtl/av2_coeff_unpacker.sv
// AV2 coefficient unpacker: turns an EOB count plus level symbols into a
// full zero-filled coefficient block on a valid/ready stream.
// Optional build macro COEFF_DEQUANT_EN scales magnitudes by dq_scale >> DQ_SHIFT.
module av2_coeff_unpacker
    import av2_coeff_pkg::*;
#(
    parameter int COEFF_W     = 16,
    parameter int SYM_W       = 16,
    parameter int MAX_TX_LOG2 = 6,
    parameter int POS_W       = 2 * MAX_TX_LOG2,
    parameter int DQ_W        = 12,
    parameter int DQ_SHIFT    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         tx_w_log2,
    input  logic [2:0]         tx_h_log2,
    input  logic               scan_col,
    input  logic [DQ_W-1:0]    dq_scale,
    output logic               busy,
    output logic               done,
    output logic               err_eob,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [SYM_W-1:0]   sym_data,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic [COEFF_W-1:0] coeff_data,
    output logic [POS_W-1:0]   coeff_pos,
    output logic               coeff_last
);

    // Counts reach N = 2^POS_W, so they need one extra bit.
    localparam int CNT_W = POS_W + 1;
    localparam int MAG_W = SYM_W - 1;
`ifdef COEFF_DEQUANT_EN
    localparam int PROD_W = MAG_W + DQ_W;
`else
    localparam int PROD_W = MAG_W;
`endif
    localparam int SAT_W = (PROD_W > COEFF_W) ? PROD_W : COEFF_W;
    localparam int CMP_W = (SYM_W > CNT_W) ? SYM_W : CNT_W;
    localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'((64'd1 << (COEFF_W - 1)) - 64'd1);

    state_e             state_q,       state_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               err_eob_q,     err_eob_d;
    logic [2:0]         w_q,           w_d;
    logic [2:0]         h_q,           h_d;
    logic               scan_col_q,    scan_col_d;
    logic [CNT_W-1:0]   n_q,           n_d;
    logic [CNT_W-1:0]   eob_q,         eob_d;
    logic [CNT_W-1:0]   k_q,           k_d;
    logic               coeff_valid_q, coeff_valid_d;
    logic [COEFF_W-1:0] coeff_data_q,  coeff_data_d;
    logic [POS_W-1:0]   coeff_pos_q,   coeff_pos_d;
    logic               coeff_last_q,  coeff_last_d;
`ifdef COEFF_DEQUANT_EN
    logic [DQ_W-1:0]    dq_scale_q,    dq_scale_d;
`else
    logic [DQ_W-1:0]    unused_dq;
    assign unused_dq = dq_scale >> DQ_SHIFT;
`endif

    logic               out_free;
    logic [CNT_W-1:0]   k_inc;
    logic [POS_W-1:0]   map_pos;
    logic [CMP_W-1:0]   sym_ext;
    logic [CMP_W-1:0]   n_ext;
    logic               eob_over;
    logic [CNT_W-1:0]   eob_val;
    logic               lvl_sign;
    logic [MAG_W-1:0]   lvl_mag;
    logic [PROD_W-1:0]  lvl_prod;
    logic [SAT_W-1:0]   lvl_wide;
    logic [COEFF_W-2:0] lvl_sat;
    logic [COEFF_W-1:0] lvl_value;

    // The single output register can take a new coefficient when empty or draining.
    assign out_free  = !coeff_valid_q || coeff_ready;
    assign k_inc     = k_q + CNT_W'(1);
    assign sym_ready = (state_q == ST_EOB) || ((state_q == ST_LEVEL) && out_free);

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_eob     = err_eob_q;
    assign coeff_valid = coeff_valid_q;
    assign coeff_data  = coeff_data_q;
    assign coeff_pos   = coeff_pos_q;
    assign coeff_last  = coeff_last_q;

    av2_scan_pos_map #(
        .MAX_TX_LOG2 (MAX_TX_LOG2),
        .POS_W       (POS_W)
    ) u_scan_pos_map (
        .k        (k_q[POS_W-1:0]),
        .w_log2   (w_q),
        .h_log2   (h_q),
        .scan_col (scan_col_q),
        .pos      (map_pos)
    );

    // EOB symbol is clipped to the block size; overflow is reported.
    always_comb begin
        sym_ext  = CMP_W'(sym_data);
        n_ext    = CMP_W'(n_q);
        eob_over = sym_ext > n_ext;
        eob_val  = eob_over ? n_q : sym_ext[CNT_W-1:0];
    end

    // Level symbol to signed coefficient: optional dequant, saturate, then sign.
    always_comb begin
        lvl_sign = sym_data[SYM_W-SYM_SIGN_OFS];
        lvl_mag  = sym_data[SYM_W-SYM_MAG_MSB_OFS:0];
`ifdef COEFF_DEQUANT_EN
        lvl_prod = (PROD_W'(lvl_mag) * PROD_W'(dq_scale_q)) >> DQ_SHIFT;
`else
        lvl_prod = lvl_mag;
`endif
        lvl_wide = SAT_W'(lvl_prod);
        if (lvl_wide > SAT_MAX) begin
            lvl_sat = {(COEFF_W-1){1'b1}};
        end else begin
            lvl_sat = lvl_wide[COEFF_W-2:0];
        end
        lvl_value = lvl_sign ? -{1'b0, lvl_sat} : {1'b0, lvl_sat};
    end

    // Next-state and output-register logic for the block sequencer.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_eob_d     = err_eob_q;
        w_d           = w_q;
        h_d           = h_q;
        scan_col_d    = scan_col_q;
        n_d           = n_q;
        eob_d         = eob_q;
        k_d           = k_q;
        coeff_valid_d = coeff_valid_q;
        coeff_data_d  = coeff_data_q;
        coeff_pos_d   = coeff_pos_q;
        coeff_last_d  = coeff_last_q;
`ifdef COEFF_DEQUANT_EN
        dq_scale_d    = dq_scale_q;
`endif

        if (coeff_valid_q && coeff_ready) begin
            coeff_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d        = clamp_log2(tx_w_log2, 3'(MAX_TX_LOG2));
                    h_d        = clamp_log2(tx_h_log2, 3'(MAX_TX_LOG2));
                    scan_col_d = scan_col;
                    n_d        = CNT_W'(1) << ({1'b0, w_d} + {1'b0, h_d});
`ifdef COEFF_DEQUANT_EN
                    dq_scale_d = dq_scale;
`endif
                    err_eob_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_EOB;
                end
            end
            ST_EOB: begin
                if (sym_valid) begin
                    eob_d     = eob_val;
                    err_eob_d = eob_over;
                    k_d       = '0;
                    state_d   = (eob_val == '0) ? ST_ZFILL : ST_LEVEL;
                end
            end
            ST_LEVEL: begin
                if (sym_valid && out_free) begin
                    coeff_valid_d = 1'b1;
                    coeff_data_d  = lvl_value;
                    coeff_pos_d   = map_pos;
                    coeff_last_d  = (k_inc == n_q);
                    k_d           = k_inc;
                    if (k_inc == eob_q) begin
                        state_d = ST_ZFILL;
                    end
                end
            end
            ST_ZFILL: begin
                if (coeff_valid_q && coeff_ready && coeff_last_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (out_free && (k_q < n_q)) begin
                    coeff_valid_d = 1'b1;
                    coeff_data_d  = '0;
                    coeff_pos_d   = map_pos;
                    coeff_last_d  = (k_inc == n_q);
                    k_d           = k_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and outputs registered; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_eob_q     <= 1'b0;
            w_q           <= 3'(MIN_TX_LOG2);
            h_q           <= 3'(MIN_TX_LOG2);
            scan_col_q    <= 1'b0;
            n_q           <= '0;
            eob_q         <= '0;
            k_q           <= '0;
            coeff_valid_q <= 1'b0;
            coeff_data_q  <= '0;
            coeff_pos_q   <= '0;
            coeff_last_q  <= 1'b0;
`ifdef COEFF_DEQUANT_EN
            dq_scale_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_eob_q     <= err_eob_d;
            w_q           <= w_d;
            h_q           <= h_d;
            scan_col_q    <= scan_col_d;
            n_q           <= n_d;
            eob_q         <= eob_d;
            k_q           <= k_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_data_q  <= coeff_data_d;
            coeff_pos_q   <= coeff_pos_d;
            coeff_last_q  <= coeff_last_d;
`ifdef COEFF_DEQUANT_EN
            dq_scale_q    <= dq_scale_d;
`endif
        end
    end

endmodule

// File: tb/tb_av2_coeff_unpacker.sv
// Self-checking bench for av2_coeff_unpacker built with COEFF_W = 12.
module tb_av2_coeff_unpacker;

    localparam int COEFF_W     = 12;
    localparam int SYM_W       = 16;
    localparam int MAX_TX_LOG2 = 6;
    localparam int POS_W       = 12;
    localparam int DQ_W        = 12;
`ifdef COEFF_DEQUANT_EN
    localparam bit DQ_ON = 1'b1;
`else
    localparam bit DQ_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [2:0]         tx_w_log2 = 3'd0;
    logic [2:0]         tx_h_log2 = 3'd0;
    logic               scan_col = 1'b0;
    logic [DQ_W-1:0]    dq_scale = '0;
    logic               busy, done, err_eob;
    logic               sym_valid = 1'b0;
    logic               sym_ready;
    logic [SYM_W-1:0]   sym_data = '0;
    logic               coeff_valid;
    logic               coeff_ready = 1'b0;
    logic [COEFF_W-1:0] coeff_data;
    logic [POS_W-1:0]   coeff_pos;
    logic               coeff_last;

    av2_coeff_unpacker #(
        .COEFF_W     (COEFF_W),
        .SYM_W       (SYM_W),
        .MAX_TX_LOG2 (MAX_TX_LOG2),
        .POS_W       (POS_W),
        .DQ_W        (DQ_W),
        .DQ_SHIFT    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tx_w_log2   (tx_w_log2),
        .tx_h_log2   (tx_h_log2),
        .scan_col    (scan_col),
        .dq_scale    (dq_scale),
        .busy        (busy),
        .done        (done),
        .err_eob     (err_eob),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_data    (sym_data),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .coeff_data  (coeff_data),
        .coeff_pos   (coeff_pos),
        .coeff_last  (coeff_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        w;
        logic [2:0]        h;
        logic              col;
        logic [7:0]        eob;
        logic [19:0][15:0] lv;
        logic [11:0]       dq;
        logic              rnd;
    } vec_t;

    typedef struct {
        int data;
        int pos;
        bit last;
    } exp_t;

    vec_t  vecs [6];
    exp_t  sb [$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail = 0;
    int    sym_hs = 0;
    bit    rnd_ready = 1'b0;
    bit    done_pending = 1'b0;
    bit    prev_stall = 1'b0;
    int    prev_data, prev_pos, prev_last;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampLog2(input int v);
        if (v < 2) return 2;
        if (v > MAX_TX_LOG2) return MAX_TX_LOG2;
        return v;
    endfunction

    function automatic int modelLevel(input logic [15:0] d, input logic [11:0] dq);
        int mag;
        mag = int'(d[14:0]);
        if (DQ_ON) mag = (mag * int'(dq)) >> 2;
        if (mag > 2047) mag = 2047;
        return d[15] ? -mag : mag;
    endfunction

    // Downstream ready: always on, or random when the vector asks for stalls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            coeff_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, done timing, symbol count.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall   = 1'b0;
            done_pending = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", int'(coeff_valid), 1);
                checkOutput("stall_data", int'($signed(coeff_data)), prev_data);
                checkOutput("stall_pos", int'(coeff_pos), prev_pos);
                checkOutput("stall_last", int'(coeff_last), prev_last);
            end
            checkOutput("done_pulse", int'(done), int'(done_pending));
            if (done_pending) checkOutput("busy_in_done", int'(busy), 0);
            done_pending = 1'b0;
            if (sym_valid && sym_ready) sym_hs++;
            if (coeff_valid && coeff_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("coeff_unexpected", int'(coeff_pos), -1);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("coeff_data", int'($signed(coeff_data)), mon_e.data);
                    checkOutput("coeff_pos", int'(coeff_pos), mon_e.pos);
                    checkOutput("coeff_last", int'(coeff_last), int'(mon_e.last));
                end
                if (coeff_last) done_pending = 1'b1;
            end
            prev_stall = coeff_valid && !coeff_ready;
            prev_data  = int'($signed(coeff_data));
            prev_pos   = int'(coeff_pos);
            prev_last  = int'(coeff_last);
        end
    end

    // Drive one symbol from posedge+1 until it is accepted; leaves sym_valid high.
    task automatic sendSymbol(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        sym_valid = 1'b1;
        sym_data  = d;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sym_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        checkOutput("sym_accepted", int'(ok), 1);
    endtask

    // Run one full block: push the modelled coefficients, start, feed symbols, wait for done.
    task automatic applyStimulus(input vec_t v);
        int wl, hl, n, e, hs0, r, c;
        bit seen;
        exp_t x;
        wl = clampLog2(int'(v.w));
        hl = clampLog2(int'(v.h));
        n  = 1 << (wl + hl);
        e  = (int'(v.eob) > n) ? n : int'(v.eob);
        for (int k = 0; k < n; k++) begin
            r = k % (1 << hl);
            c = k / (1 << hl);
            x.data = (k < e) ? modelLevel(v.lv[k], v.dq) : 0;
            x.pos  = v.col ? (r * (1 << wl) + c) : k;
            x.last = (k == n - 1);
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        rnd_ready = v.rnd;
        tx_w_log2 = v.w;
        tx_h_log2 = v.h;
        scan_col  = v.col;
        dq_scale  = v.dq;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("err_cleared_on_start", int'(err_eob), 0);
        hs0 = sym_hs;
        @(posedge clk);
        #1;
        sendSymbol(16'(v.eob));
        for (int k = 0; k < e; k++) sendSymbol(v.lv[k]);
        sym_data = 16'h0001;
        seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        checkOutput("done_seen", int'(seen), 1);
        checkOutput("sym_count", sym_hs - hs0, e + 1);
        checkOutput("err_eob", int'(err_eob), int'(int'(v.eob) > n));
        checkOutput("busy_idle", int'(busy), 0);
        checkOutput("sb_drained", sb.size(), 0);
    endtask

    task automatic setVec(input int i, input int w, input int h, input bit col,
                          input int eob, input int dq, input bit rnd);
        vecs[i]     = '0;
        vecs[i].w   = 3'(w);
        vecs[i].h   = 3'(h);
        vecs[i].col = col;
        vecs[i].eob = 8'(eob);
        vecs[i].dq  = 12'(dq);
        vecs[i].rnd = rnd;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err_eob", int'(err_eob), 0);
        checkOutput("rst_sym_ready", int'(sym_ready), 0);
        checkOutput("rst_coeff_valid", int'(coeff_valid), 0);
        checkOutput("rst_coeff_last", int'(coeff_last), 0);
        checkOutput("rst_coeff_data", int'(coeff_data), 0);
        checkOutput("rst_coeff_pos", int'(coeff_pos), 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setVec(0, 2, 2, 1'b0, 3, 0, 1'b0);
        vecs[0].lv[0] = 16'h0005;
        vecs[0].lv[1] = 16'h8002;
        vecs[0].lv[2] = 16'h0007;
        setVec(1, 3, 2, 1'b1, 5, 0, 1'b1);
        for (int k = 0; k < 5; k++) vecs[1].lv[k] = 16'(k + 1);
        setVec(2, 2, 2, 1'b0, 0, 0, 1'b0);
        setVec(3, 2, 2, 1'b0, 20, 0, 1'b1);
        for (int k = 0; k < 20; k++) vecs[3].lv[k] = (k % 2 == 1) ? 16'(16'h8000 | 16'(k + 1)) : 16'(k + 1);
        setVec(4, 2, 2, 1'b0, 4, 8, 1'b0);
        vecs[4].lv[0] = 16'h7FFF;
        vecs[4].lv[1] = 16'hFFFF;
        vecs[4].lv[2] = 16'h8000;
        vecs[4].lv[3] = 16'h0003;
        setVec(5, 1, 7, 1'b1, 2, 0, 1'b1);
        vecs[5].lv[0] = 16'h0010;
        vecs[5].lv[1] = 16'h8001;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of LEVEL with random stalls, then a clean block.
        $display("[TB] reset mid-block");
        rnd_ready = 1'b1;
        begin
            exp_t x;
            for (int k = 0; k < 3; k++) begin
                x.data = k + 9;
                x.pos  = k;
                x.last = 1'b0;
                sb.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        tx_w_log2 = 3'd2;
        tx_h_log2 = 3'd2;
        scan_col  = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sendSymbol(16'd10);
        sendSymbol(16'd9);
        sendSymbol(16'd10);
        sendSymbol(16'd11);
        sym_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy_before_reset", int'(busy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs();
        repeat (4) @(negedge clk);
        applyStimulus(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
